ones_comp_rx: RTL and testbench

ONES_COMP_RX -- requirements
Module: ones_comp_rx

---
 rtl/ones_comp_rx.sv | 151 +++++++++++++++
 tb/tb_ones_comp_rx.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ones_comp_rx.sv
// Serial one's-complement line receiver: re-inverts LSB-first bits into words and frames them.
// Define ONES_RX_CSUM_EN to include the end-around-carry frame checksum; otherwise csum/csum_ok stay 0.
module ones_comp_rx #(
    parameter int WIDTH       = 8,
    parameter int FRAME_WORDS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_data,
    input  logic             in_valid,
    input  logic             sof,
    output logic [WIDTH-1:0] out_word,
    output logic             out_valid,
    output logic             frame_done,
    output logic             csum_ok,
    output logic [WIDTH-1:0] csum
);

    localparam int              BW        = $clog2(WIDTH);
    localparam logic [BW-1:0]   LAST_BIT  = BW'(WIDTH - 1);
    localparam logic [7:0]      LAST_WORD = 8'(FRAME_WORDS - 1);

    typedef enum logic {
        IDLE,
        RECV
    } state_t;

    state_t           state_q, state_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]       word_cnt_q, word_cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] word_asm;
    logic [WIDTH-1:0] out_word_q, out_word_d;
    logic             out_valid_q, out_valid_d;
    logic             frame_done_q, frame_done_d;

`ifdef ONES_RX_CSUM_EN
    logic [WIDTH-1:0] acc_q, acc_d, acc_next;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] csum_q, csum_d;
    logic             csum_ok_q, csum_ok_d;

    // End-around carry: the carry out of the word add is folded back into bit 0.
    always_comb begin
        sum      = {1'b0, acc_q} + {1'b0, word_asm};
        acc_next = sum[WIDTH-1:0] + WIDTH'(sum[WIDTH]);
    end
`endif

    always_comb begin
        word_asm           = shift_q;
        word_asm[bit_cnt_q] = ~in_data;
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        word_cnt_d   = word_cnt_q;
        shift_d      = shift_q;
        out_word_d   = out_word_q;
        out_valid_d  = 1'b0;
        frame_done_d = 1'b0;
`ifdef ONES_RX_CSUM_EN
        acc_d        = acc_q;
        csum_d       = csum_q;
        csum_ok_d    = csum_ok_q;
`endif
        if (in_valid) begin
            // sof wins over everything, including a word completing on this same edge.
            if (sof) begin
                state_d    = RECV;
                shift_d    = '0;
                shift_d[0] = ~in_data;
                bit_cnt_d  = BW'(1);
                word_cnt_d = '0;
`ifdef ONES_RX_CSUM_EN
                acc_d      = '0;
                csum_d     = '0;
                csum_ok_d  = 1'b0;
`endif
            end else if (state_q == RECV) begin
                shift_d = word_asm;
                if (bit_cnt_q == LAST_BIT) begin
                    bit_cnt_d   = '0;
                    out_word_d  = word_asm;
                    out_valid_d = 1'b1;
                    word_cnt_d  = word_cnt_q + 8'd1;
`ifdef ONES_RX_CSUM_EN
                    acc_d       = acc_next;
`endif
                    if (word_cnt_q == LAST_WORD) begin
                        frame_done_d = 1'b1;
                        word_cnt_d   = '0;
                        state_d      = IDLE;
`ifdef ONES_RX_CSUM_EN
                        csum_d       = acc_next;
                        csum_ok_d    = &acc_next;
`endif
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + BW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            word_cnt_q   <= '0;
            shift_q      <= '0;
            out_word_q   <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            word_cnt_q   <= word_cnt_d;
            shift_q      <= shift_d;
            out_word_q   <= out_word_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

`ifdef ONES_RX_CSUM_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q     <= '0;
            csum_q    <= '0;
            csum_ok_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            csum_q    <= csum_d;
            csum_ok_q <= csum_ok_d;
        end
    end

    assign csum    = csum_q;
    assign csum_ok = csum_ok_q;
`else
    assign csum    = '0;
    assign csum_ok = 1'b0;
`endif

    assign out_word   = out_word_q;
    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ones_comp_rx.sv
// Bench for ones_comp_rx: directed and randomized frames against a word-level model.
// Checksum expectations follow ONES_RX_CSUM_EN as seen by this compile.
module tb_ones_comp_rx;

    localparam int          W    = 8;
    localparam int          FW   = 4;
    localparam int unsigned MASK = (1 << W) - 1;

    typedef logic [W-1:0] frame_t [FW];
    typedef struct packed {
        logic [W-1:0] w;
        logic         fd;
        logic [W-1:0] cs;
        logic         ok;
    } ev_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_data;
    logic         in_valid;
    logic         sof;
    logic [W-1:0] out_word;
    logic         out_valid;
    logic         frame_done;
    logic         csum_ok;
    logic [W-1:0] csum;

    int  n_checks = 0;
    int  n_fail   = 0;
    ev_t obs_q[$];
    ev_t exp_q[$];
    logic prev_ov = 1'b0;

    always #5 clk = ~clk;

    ones_comp_rx #(.WIDTH(W), .FRAME_WORDS(FW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .sof       (sof),
        .out_word  (out_word),
        .out_valid (out_valid),
        .frame_done(frame_done),
        .csum_ok   (csum_ok),
        .csum      (csum)
    );

    // Output monitor: records every word pulse, and enforces single-cycle pulses.
    always @(negedge clk) begin
        ev_t e;
        if (out_valid === 1'b1) begin
            n_checks++;
            if (prev_ov === 1'b1) begin
                n_fail++;
                $display("FAIL pulse_width: out_valid high for 2 consecutive cycles, required 1");
            end
            e.w  = out_word;
            e.fd = frame_done;
            e.cs = frame_done ? csum : '0;
            e.ok = frame_done ? csum_ok : 1'b0;
            obs_q.push_back(e);
        end
        if (frame_done === 1'b1) begin
            n_checks++;
            if (out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL fd_with_ov: out_valid=%b at frame_done, required 1", out_valid);
            end
        end
        prev_ov = out_valid;
    end

    // One's-complement sum of a whole frame by folding carries at the end.
    function automatic logic [W-1:0] oc_fold(input int unsigned total);
        int unsigned s = total;
        while (s > MASK) s = (s & MASK) + (s >> W);
        return W'(s);
    endfunction

    task automatic push_frame(input frame_t f);
        ev_t e;
`ifdef ONES_RX_CSUM_EN
        int unsigned total = 0;
        for (int i = 0; i < FW; i++) total += int'(f[i]);
`endif
        for (int i = 0; i < FW; i++) begin
            e.w  = f[i];
            e.fd = (i == FW - 1);
            e.cs = '0;
            e.ok = 1'b0;
`ifdef ONES_RX_CSUM_EN
            if (i == FW - 1) begin
                e.cs = oc_fold(total);
                e.ok = (e.cs == W'(MASK));
            end
`endif
            exp_q.push_back(e);
        end
    endtask

    task automatic push_word(input logic [W-1:0] w);
        ev_t e;
        e.w = w; e.fd = 1'b0; e.cs = '0; e.ok = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            sof      = 1'b0;
        end
    endtask

    // Stall cycles carry random data and sof, which must be ignored with in_valid low.
    task automatic stall(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 1'($urandom);
            sof      = 1'($urandom);
        end
    endtask

    task automatic drive_bit(input logic b, input logic s);
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        sof      = s;
    endtask

    task automatic send_word(input logic [W-1:0] w, input logic first, input int stall_pct);
        for (int b = 0; b < W; b++) begin
            if (stall_pct > 0 && int'($urandom_range(99)) < stall_pct) stall(int'($urandom_range(1, 3)));
            drive_bit(~w[b], first && (b == 0));
        end
    endtask

    task automatic send_frame(input frame_t f, input int stall_pct);
        for (int i = 0; i < FW; i++) send_word(f[i], i == 0, stall_pct);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (out_word !== '0)    begin n_fail++; $display("FAIL reset_out_word: got %h, required 00", out_word); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b, required 0", frame_done); end
        n_checks++; if (csum_ok !== 1'b0)   begin n_fail++; $display("FAIL reset_csum_ok: got %b, required 0", csum_ok); end
        n_checks++; if (csum !== '0)        begin n_fail++; $display("FAIL reset_csum: got %h, required 00", csum); end
        rst = 1'b1;
        idle(2);
    endtask

    task automatic test_directed;
        frame_t tbl [3];
        tbl[0] = '{8'h12, 8'h34, 8'h56, 8'h63};
        tbl[1] = '{8'hF0, 8'h20, 8'h01, 8'hED};
        tbl[2] = '{8'h12, 8'h34, 8'h56, 8'h62};
        for (int t = 0; t < 3; t++) begin
            obs_q.delete(); exp_q.delete();
            push_frame(tbl[t]);
            send_frame(tbl[t], 0);
            idle(3);
            n_checks++;
            if (obs_q.size() != exp_q.size()) begin
                n_fail++;
                $display("FAIL directed%0d_count: got %0d words, required %0d", t, obs_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
                n_checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL directed%0d_word%0d: got w=%h fd=%b csum=%h ok=%b, required w=%h fd=%b csum=%h ok=%b",
                             t, i, obs_q[i].w, obs_q[i].fd, obs_q[i].cs, obs_q[i].ok,
                             exp_q[i].w, exp_q[i].fd, exp_q[i].cs, exp_q[i].ok);
                end
            end
        end
    endtask

    task automatic test_stall_abort;
        frame_t f0, f1;
        f0 = '{8'h12, 8'h34, 8'h56, 8'h63};
        for (int i = 0; i < FW; i++) f1[i] = W'($urandom);
        obs_q.delete(); exp_q.delete();
        push_word(f0[0]);
        push_word(f0[1]);
        push_frame(f1);
        send_word(f0[0], 1'b1, 0);
        for (int b = 0; b < W; b++) begin
            if (b == 3) stall(5);
            drive_bit(~f0[1][b], 1'b0);
        end
        for (int b = 0; b < 4; b++) drive_bit(~f0[2][b], 1'b0);
        send_frame(f1, 0);
        idle(3);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL stall_abort_count: got %0d words, required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL stall_abort_word%0d: got w=%h fd=%b csum=%h ok=%b, required w=%h fd=%b csum=%h ok=%b",
                         i, obs_q[i].w, obs_q[i].fd, obs_q[i].cs, obs_q[i].ok,
                         exp_q[i].w, exp_q[i].fd, exp_q[i].cs, exp_q[i].ok);
            end
        end
    endtask

    task automatic test_reset_midframe;
        frame_t f;
        f = '{8'h12, 8'h34, 8'h56, 8'h63};
        obs_q.delete(); exp_q.delete();
        push_word(f[0]);
        send_word(f[0], 1'b1, 0);
        for (int b = 0; b < 3; b++) drive_bit(~f[1][b], 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({out_word, out_valid, frame_done, csum_ok, csum} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got w=%h ov=%b fd=%b ok=%b csum=%h, required all 0",
                     out_word, out_valid, frame_done, csum_ok, csum);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int b = 0; b < 2 * W; b++) drive_bit(1'($urandom), 1'b0);
        idle(3);
        n_checks++;
        if (obs_q.size() != 1) begin
            n_fail++;
            $display("FAIL midreset_ignore: got %0d words before sof, required 1", obs_q.size());
        end
        push_frame(f);
        send_frame(f, 0);
        idle(3);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL midreset_count: got %0d words, required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL midreset_word%0d: got w=%h fd=%b csum=%h ok=%b, required w=%h fd=%b csum=%h ok=%b",
                         i, obs_q[i].w, obs_q[i].fd, obs_q[i].cs, obs_q[i].ok,
                         exp_q[i].w, exp_q[i].fd, exp_q[i].cs, exp_q[i].ok);
            end
        end
    endtask

    task automatic test_back_to_back;
        frame_t f;
        obs_q.delete(); exp_q.delete();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < FW; i++) f[i] = W'($urandom);
            push_frame(f);
            send_frame(f, 0);
        end
        idle(3);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d words, required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL b2b_word%0d: got w=%h fd=%b csum=%h ok=%b, required w=%h fd=%b csum=%h ok=%b",
                         i, obs_q[i].w, obs_q[i].fd, obs_q[i].cs, obs_q[i].ok,
                         exp_q[i].w, exp_q[i].fd, exp_q[i].cs, exp_q[i].ok);
            end
        end
    endtask

    task automatic test_random;
        frame_t f;
        int unsigned part;
        int k, p;
        obs_q.delete(); exp_q.delete();
        for (int n = 0; n < 30; n++) begin
            // Occasionally open a frame and abandon it part-way through a word.
            if ($urandom_range(3) == 0) begin
                k = int'($urandom_range(FW - 1));
                p = int'($urandom_range(1, W - 1));
                for (int i = 0; i < k; i++) begin
                    f[i] = W'($urandom);
                    push_word(f[i]);
                    send_word(f[i], i == 0, 15);
                end
                for (int b = 0; b < p; b++) drive_bit(1'($urandom), (k == 0) && (b == 0));
            end
            part = 0;
            for (int i = 0; i < FW; i++) f[i] = W'($urandom);
            for (int i = 0; i < FW - 1; i++) part += int'(f[i]);
            if ($urandom_range(1) == 1) f[FW-1] = ~oc_fold(part);
            push_frame(f);
            send_frame(f, 20);
            stall(int'($urandom_range(0, 3)));
        end
        idle(3);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL random_count: got %0d words, required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL random_word%0d: got w=%h fd=%b csum=%h ok=%b, required w=%h fd=%b csum=%h ok=%b",
                         i, obs_q[i].w, obs_q[i].fd, obs_q[i].cs, obs_q[i].ok,
                         exp_q[i].w, exp_q[i].fd, exp_q[i].cs, exp_q[i].ok);
            end
        end
    endtask

    initial begin
        rst      = 1'b0;
        in_data  = 1'b0;
        in_valid = 1'b0;
        sof      = 1'b0;
        test_reset();
        test_directed();
        test_stall_abort();
        test_reset_midframe();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
